div_unit: RTL and testbench

- Multi-cycle iterative integer divider in the EX stage, used for DIV/DIVU.
- EX holds start_i high and raises stallreq_from_ex toward the stall controller until ready_o is seen. The controller then freezes PC through EX (stall = 6'b001111).
- Produces {remainder, quotient} for the HI/LO write path.
- annul_i lets the pipeline cancel an in-flight divide on flush.

---
 rtl/div_unit.sv | 156 +++++++++++++++
 tb/tb_div_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU in the EX stage.
// Produces {remainder, quotient}; ready_o rises DATA_W+2 edges after acceptance (2 for a zero divisor).
module div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  typedef enum logic [1:0] {S_FREE, S_ZERO, S_ON, S_END} state_t;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [DATA_W-1:0]     rem_reg, rem_next;
  logic [DATA_W-1:0]     quo_reg, quo_next;
  logic [DATA_W-1:0]     dsr_reg, dsr_next;
  logic                  sgn_reg, sgn_next;
  logic                  neg1_reg, neg1_next;
  logic                  neg2_reg, neg2_next;
  logic [2*DATA_W-1:0]   result_reg, result_next;
  logic                  ready_reg, ready_next;

  logic                  accept;
  logic                  last_step;
  logic [DATA_W-1:0]     mag1;
  logic [DATA_W-1:0]     mag2;
  logic [DATA_W:0]       shifted;
  logic [DATA_W:0]       diff;

  assign accept    = start_i && !annul_i;
  assign last_step = (cnt_reg == CNT_W'(DATA_W));
  assign mag1      = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign mag2      = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
  // quo_reg doubles as the dividend shift register; its MSB feeds the partial remainder
  assign shifted   = {rem_reg, quo_reg[DATA_W-1]};
  assign diff      = shifted - {1'b0, dsr_reg};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_FREE;
      cnt_reg    <= '0;
      rem_reg    <= '0;
      quo_reg    <= '0;
      dsr_reg    <= '0;
      sgn_reg    <= 1'b0;
      neg1_reg   <= 1'b0;
      neg2_reg   <= 1'b0;
      result_reg <= '0;
      ready_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      rem_reg    <= rem_next;
      quo_reg    <= quo_next;
      dsr_reg    <= dsr_next;
      sgn_reg    <= sgn_next;
      neg1_reg   <= neg1_next;
      neg2_reg   <= neg2_next;
      result_reg <= result_next;
      ready_reg  <= ready_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FREE: begin
        if (accept) state_next = (opdata2_i == '0) ? S_ZERO : S_ON;
      end
      S_ZERO: state_next = S_END;
      S_ON: begin
        if (annul_i)        state_next = S_FREE;
        else if (last_step) state_next = S_END;
      end
      S_END: begin
        if (!start_i) state_next = S_FREE;
      end
      default: state_next = S_FREE;
    endcase
  end

  always_comb begin
    cnt_next    = cnt_reg;
    rem_next    = rem_reg;
    quo_next    = quo_reg;
    dsr_next    = dsr_reg;
    sgn_next    = sgn_reg;
    neg1_next   = neg1_reg;
    neg2_next   = neg2_reg;
    result_next = result_reg;
    ready_next  = ready_reg;
    case (state_reg)
      S_FREE: begin
        result_next = '0;
        ready_next  = 1'b0;
        if (accept) begin
          cnt_next  = '0;
          rem_next  = '0;
          quo_next  = mag1;
          dsr_next  = mag2;
          sgn_next  = signed_div_i;
          neg1_next = opdata1_i[DATA_W-1];
          neg2_next = opdata2_i[DATA_W-1];
        end
      end
      S_ZERO: begin
        rem_next = '0;
        quo_next = '0;
      end
      S_ON: begin
        if (annul_i) begin
          cnt_next = '0;
        end else if (!last_step) begin
          if (!diff[DATA_W]) begin
            rem_next = diff[DATA_W-1:0];
            quo_next = {quo_reg[DATA_W-2:0], 1'b1};
          end else begin
            rem_next = shifted[DATA_W-1:0];
            quo_next = {quo_reg[DATA_W-2:0], 1'b0};
          end
          cnt_next = cnt_reg + CNT_W'(1);
        end else begin
          // Sign fix-up: quotient follows sign mismatch, remainder follows the dividend
          quo_next = (sgn_reg && (neg1_reg ^ neg2_reg)) ? -quo_reg : quo_reg;
          rem_next = (sgn_reg && neg1_reg) ? -rem_reg : rem_reg;
          cnt_next = '0;
        end
      end
      S_END: begin
        if (start_i) begin
          result_next = {rem_reg, quo_reg};
          ready_next  = 1'b1;
        end else begin
          result_next = '0;
          ready_next  = 1'b0;
        end
      end
      default: begin
        result_next = '0;
        ready_next  = 1'b0;
      end
    endcase
  end

  assign result_o = result_reg;
  assign ready_o  = ready_reg;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, results, handshake, annul and reset.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (opdata1),
    .opdata2_i    (opdata2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Applies one divide and checks latency (posedges including the start edge), result,
  // the held result while start stays high, and the clear once start drops.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int exp_lat,
                         input bit perturb);
    int cyc;
    signed_div = sgn;
    opdata1    = a;
    opdata2    = b;
    start      = 1'b1;
    cyc        = 0;
    do begin
      tick();
      cyc++;
      if (perturb && cyc == 5) begin
        opdata1    = $urandom;
        opdata2    = $urandom | 32'd1;
        signed_div = ~sgn;
      end
    end while (!ready && cyc < 60);
    check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_res"}, result, exp);
    for (int i = 0; i < 5; i++) begin
      tick();
      check({tag, "_hold_rdy"}, 64'(ready), 64'd1);
      check({tag, "_hold_res"}, result, exp);
    end
    start = 1'b0;
    tick();
    check({tag, "_clr_rdy"}, 64'(ready), 64'd0);
    check({tag, "_clr_res"}, result, 64'd0);
    $display("vec %s: a=%h b=%h signed=%0d -> %h after %0d edges", tag, a, b, sgn, exp, cyc);
  endtask

  initial begin
    int  cyc;
    bit  seen;
    rst        = 1'b1;
    signed_div = 1'b0;
    opdata1    = '0;
    opdata2    = '0;
    start      = 1'b0;
    annul      = 1'b0;
    tick();
    tick();
    check("reset_rdy", 64'(ready), 64'd0);
    check("reset_res", result, 64'd0);
    rst = 1'b0;
    tick();

    run_div("u100_7",    1'b0, 32'd100,       32'd7,         {32'd2, 32'd14},                   35, 1'b0);
    run_div("s_m7_2",    1'b1, 32'hFFFFFFF9,  32'd2,         {32'hFFFFFFFF, 32'hFFFFFFFD},      35, 1'b0);
    run_div("s_7_m2",    1'b1, 32'd7,         32'hFFFFFFFE,  {32'd1, 32'hFFFFFFFD},             35, 1'b0);
    run_div("u_f9_2",    1'b0, 32'hFFFFFFF9,  32'd2,         {32'd1, 32'h7FFFFFFC},             35, 1'b0);
    run_div("div0",      1'b0, 32'h12345678,  32'd0,         64'd0,                             3,  1'b0);
    run_div("s_div0",    1'b1, 32'hFFFFFFFF,  32'd0,         64'd0,                             3,  1'b0);
    run_div("s_ovf",     1'b1, 32'h80000000,  32'hFFFFFFFF,  {32'd0, 32'h80000000},             35, 1'b0);
    run_div("u_max_10",  1'b0, 32'hFFFFFFFF,  32'd10,        {32'd5, 32'h19999999},             35, 1'b0);
    run_div("u_msb_3",   1'b0, 32'h80000000,  32'd3,         {32'd2, 32'h2AAAAAAA},             35, 1'b0);
    run_div("s_m100_m7", 1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  {32'hFFFFFFFE, 32'd14},            35, 1'b0);
    run_div("u_5_9",     1'b0, 32'd5,         32'd9,         {32'd5, 32'd0},                    35, 1'b0);
    run_div("perturb",   1'b0, 32'd100,       32'd7,         {32'd2, 32'd14},                   35, 1'b1);

    // Annul sampled at edge 10 and held with start: the divide must never complete.
    signed_div = 1'b0;
    opdata1    = 32'd100;
    opdata2    = 32'd7;
    start      = 1'b1;
    repeat (10) tick();
    annul = 1'b1;
    seen  = 1'b0;
    repeat (40) begin
      tick();
      if (ready) seen = 1'b1;
    end
    check("annul_no_rdy", 64'(seen), 64'd0);
    annul = 1'b0;
    start = 1'b0;
    tick();
    $display("vec annul: divide cancelled at edge 10");
    run_div("after_annul", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 35, 1'b0);

    // Reset at edge 20 of a divide, then restart with start still high.
    opdata1 = 32'd100;
    opdata2 = 32'd7;
    start   = 1'b1;
    repeat (20) tick();
    rst = 1'b1;
    tick();
    check("rst_mid_rdy", 64'(ready), 64'd0);
    check("rst_mid_res", result, 64'd0);
    rst = 1'b0;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!ready && cyc < 60);
    check("rst_restart_lat", 64'(cyc), 64'd35);
    check("rst_restart_res", result, {32'd2, 32'd14});
    // Reset while holding a result in END.
    rst = 1'b1;
    tick();
    check("rst_end_rdy", 64'(ready), 64'd0);
    check("rst_end_res", result, 64'd0);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    check("rst_idle_rdy", 64'(ready), 64'd0);
    $display("vec reset: mid-divide and in END");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
